// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux_seq_n registered multiplexer.
// State encoding, mode constants and the lowest-set-bit helper.
package mux_seq_pkg;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest channel mask the priority encoder accepts.
  localparam int MAX_N = 256;

  // Index of the lowest set bit. Returns 0 for an all-zero vector.
  function automatic int unsigned lowest_set(input logic [MAX_N-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_seq_n_if.sv
// Request/response bundle for mux_seq_n.
// slave = the multiplexer, master = whatever drives it.
interface mux_seq_n_if #(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) ();

  logic            mode;
  logic [SW-1:0]   sel;
  logic            in_valid;
  logic            start;
  logic [N-1:0]    ch_mask;
  logic [N*W-1:0]  in_data;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            out_par;

  // Output handshake: a word transfers on any cycle where out_valid and
  // out_ready are both high; out_data/out_ch/out_par stay stable while
  // out_valid is high and out_ready is low.
  modport slave (
    input  mode, sel, in_valid, start, ch_mask, in_data, out_ready,
    output out_data, out_ch, out_valid, busy, done, out_par
  );

  modport master (
    output mode, sel, in_valid, start, ch_mask, in_data, out_ready,
    input  out_data, out_ch, out_valid, busy, done, out_par
  );

endinterface

// File: rtl/mux_tree_n.sv
// Combinational N:1, W-bit mux built recursively from 2:1 stages.
// N may be any value >= 2; out-of-range selects return an unspecified channel.
module mux_tree_n #(
  parameter  int N  = 16,
  parameter  int W  = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0] data,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out
);

  // Lower half holds channels [0, LO), upper half holds [LO, N).
  localparam int LO = N / 2;
  localparam int HI = N - LO;

  logic [W-1:0] lo_out;
  logic [W-1:0] hi_out;

  if (LO == 1) begin : g_lo_leaf
    assign lo_out = data[W-1:0];
  end else begin : g_lo_tree
    localparam int SWL = $clog2(LO);
    mux_tree_n #(.N(LO), .W(W)) u_lo (
      .data (data[LO*W-1:0]),
      .sel  (SWL'(sel)),
      .out  (lo_out)
    );
  end

  if (HI == 1) begin : g_hi_leaf
    assign hi_out = data[N*W-1 -: W];
  end else begin : g_hi_tree
    localparam int SWH = $clog2(HI);
    mux_tree_n #(.N(HI), .W(W)) u_hi (
      .data (data[N*W-1:LO*W]),
      .sel  (SWH'(sel - SW'(LO))),
      .out  (hi_out)
    );
  end

  assign out = (sel < SW'(LO)) ? lo_out : hi_out;

endmodule

// File: rtl/mux_seq_n.sv
// N-channel, W-bit registered mux with direct-select and mask-scan modes.
// Optional even parity on out_par when MUX_SEQ_PARITY_EN is defined.
module mux_seq_n
  import mux_seq_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  mux_seq_n_if.slave     bus,
  output state_t         dbg_state
);

  state_t        state;
  logic [N-1:0]  pend;
  logic [N-1:0]  cur_hot;
  logic [SW-1:0] cur;
  logic [SW-1:0] tree_sel;
  logic [W-1:0]  tree_out;
  logic [W-1:0]  load_word;
  logic          slot_free;
  logic          load_en;
  logic          last_load;

  always_comb begin
    cur          = SW'(lowest_set(MAX_N'(pend)));
    cur_hot      = '0;
    cur_hot[cur] = 1'b1;
    tree_sel     = (state == SCAN) ? cur : bus.sel;
    slot_free    = !bus.out_valid || bus.out_ready;
    // Direct selects beyond the last channel load zero; scan indices are always in range.
    load_word    = ((state == SCAN) || ({1'b0, bus.sel} < (SW+1)'(N))) ? tree_out : '0;
    load_en      = slot_free &&
                   ((state == SCAN) ||
                    (bus.mode == MODE_DIRECT && bus.in_valid));
    last_load    = (pend == cur_hot);
  end

  mux_tree_n #(.N(N), .W(W)) u_tree (
    .data (bus.in_data),
    .sel  (tree_sel),
    .out  (tree_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pend          <= '0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (slot_free) bus.out_valid <= 1'b0;
      if (load_en) begin
        bus.out_data  <= load_word;
        bus.out_ch    <= tree_sel;
        bus.out_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.mode == MODE_SCAN && bus.start) begin
            pend <= bus.ch_mask;
            if (bus.ch_mask == '0) begin
              bus.done <= 1'b1;
            end else begin
              state    <= SCAN;
              bus.busy <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (slot_free) begin
            pend <= pend & ~cur_hot;
            if (last_load) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_SEQ_PARITY_EN
  logic par;
  always_ff @(posedge clk) begin
    if (rst)          par <= 1'b0;
    else if (load_en) par <= ^load_word;
  end
  assign bus.out_par = par;
`else
  assign bus.out_par = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_mux_seq_n.sv
// Directed bench for mux_seq_n: reset, direct select, scan, backpressure,
// empty mask, ignored start, live in_data and parity.
module tb_mux_seq_n;
  import mux_seq_pkg::*;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     n_cmp = 0;
  int     n_err = 0;

  mux_seq_n_if #(.N(N), .W(W)) bus ();

  mux_seq_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [W-1:0] d);
`ifdef MUX_SEQ_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_out(input string tag, input logic [W-1:0] d, input logic [SW-1:0] ch,
                           input logic v);
    check({tag, ".data"},  32'(bus.out_data),  32'(d));
    check({tag, ".ch"},    32'(bus.out_ch),    32'(ch));
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".par"},   32'(bus.out_par),   32'(exp_par(d)));
  endtask

  task automatic check_flags(input string tag, input logic b, input logic dn);
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".done"}, 32'(bus.done), 32'(dn));
  endtask

  task automatic load_pattern();
    for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 8'h10 + 8'(k);
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = MODE_DIRECT; bus.sel = '0; bus.in_valid = 1'b0; bus.start = 1'b0;
    bus.ch_mask = '0; bus.out_ready = 1'b1;
    load_pattern();
    tick(); tick();
    rst = 1'b0;
    check_out("reset", 8'h00, 4'd0, 1'b0);
    check_flags("reset", 1'b0, 1'b0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));

    // Direct mode
    bus.sel = 4'd5; bus.in_valid = 1'b1;
    tick();
    check_out("dir5", 8'h15, 4'd5, 1'b1);
    bus.sel = 4'd15;
    tick();
    check_out("dir15", 8'h1F, 4'd15, 1'b1);
    bus.sel = 4'd3;
    tick();
    check_out("dir3", 8'h13, 4'd3, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    check_out("dir_idle", 8'h13, 4'd3, 1'b0);

    // Direct backpressure: a request while the slot is full is dropped
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sel = 4'd2;
    tick();
    check_out("dir_bp_load", 8'h12, 4'd2, 1'b1);
    bus.sel = 4'd7;
    tick();
    check_out("dir_bp_hold", 8'h12, 4'd2, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    check_out("dir_bp_free", 8'h17, 4'd7, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    check("dir_bp_drain.valid", 32'(bus.out_valid), 32'd0);

    // Scan 16'h8421; start/mask changes mid-scan are ignored, in_data is live
    bus.mode = MODE_SCAN; bus.ch_mask = 16'h8421; bus.start = 1'b1;
    tick();
    check_flags("scan_start", 1'b1, 1'b0);
    check("scan_start.valid", 32'(bus.out_valid), 32'd0);
    check("scan_start.state", 32'(dbg_state), 32'(SCAN));
    bus.start = 1'b0;
    tick();
    check_out("scan_w0", 8'h10, 4'd0, 1'b1);
    check_flags("scan_w0", 1'b1, 1'b0);
    bus.start = 1'b1; bus.ch_mask = 16'hFFFF; bus.mode = MODE_DIRECT;
    tick();
    check_out("scan_w1", 8'h15, 4'd5, 1'b1);
    check_flags("scan_w1", 1'b1, 1'b0);
    bus.start = 1'b0; bus.mode = MODE_SCAN;
    tick();
    check_out("scan_w2", 8'h1A, 4'd10, 1'b1);
    check_flags("scan_w2", 1'b1, 1'b0);
    bus.in_data[15*W +: W] = 8'hEE;
    tick();
    check_out("scan_w3", 8'hEE, 4'd15, 1'b1);
    check_flags("scan_w3", 1'b0, 1'b1);
    load_pattern();
    tick();
    check("scan_end.valid", 32'(bus.out_valid), 32'd0);
    check_flags("scan_end", 1'b0, 1'b0);

    // Scan backpressure, mask 16'h0003
    bus.ch_mask = 16'h0003; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_out("bp_w0", 8'h10, 4'd0, 1'b1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("bp_hold", 8'h10, 4'd0, 1'b1);
      check_flags("bp_hold", 1'b1, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    check_out("bp_w1", 8'h11, 4'd1, 1'b1);
    check_flags("bp_w1", 1'b0, 1'b1);
    tick();
    check("bp_drain.valid", 32'(bus.out_valid), 32'd0);
    check_flags("bp_drain", 1'b0, 1'b0);

    // Empty mask: done pulse only
    bus.ch_mask = 16'h0000; bus.start = 1'b1;
    tick();
    check_flags("empty", 1'b0, 1'b1);
    check("empty.valid", 32'(bus.out_valid), 32'd0);
    bus.start = 1'b0;
    tick();
    check_flags("empty_after", 1'b0, 1'b0);
    check("empty_after.valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-scan, then restart from channel 0
    bus.ch_mask = 16'hFFFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_out("rs_w0", 8'h10, 4'd0, 1'b1);
    tick();
    check_out("rs_w1", 8'h11, 4'd1, 1'b1);
    tick();
    check_out("rs_w2", 8'h12, 4'd2, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rs_reset", 8'h00, 4'd0, 1'b0);
    check_flags("rs_reset", 1'b0, 1'b0);
    tick();
    check_flags("rs_quiet", 1'b0, 1'b0);
    check("rs_quiet.valid", 32'(bus.out_valid), 32'd0);
    bus.start = 1'b1;
    tick();
    check_flags("rs_restart", 1'b1, 1'b0);
    bus.start = 1'b0;
    tick();
    check_out("rs_again_w0", 8'h10, 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_seq_n.md
Name: mux_seq_n

Overview:
Parametrised N-channel, W-bit registered multiplexer; generalises the fixed 16:1 single-bit mux tree.
- Direct mode: selects one channel per request via `sel`.
- Scan mode: after `start`, walks all channels enabled in `ch_mask`, lowest index first, emitting one word per accepted output slot.
- Output is a single registered stage with valid/ready handshake; feeds downstream serialisers and capture logic.

Parameters:
- N, 16, number of input channels (>=2, any value, not restricted to powers of two).
- W, 8, data width per channel.
- SW, $clog2(N), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct, 1 = scan; sampled only in IDLE.
- sel  input  SW  channel index for direct mode.
- in_valid  input  1  direct-mode capture request.
- start  input  1  scan-mode launch pulse.
- ch_mask  input  N  scan channel enables; sampled at start.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- out_data  output  W  registered selected word.
- out_ch  output  SW  index of channel held in out_data.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  downstream accept.
- busy  output  1  high while state = SCAN.
- done  output  1  one-cycle pulse at scan completion.
- out_par  output  1  even parity of out_data (see Optional Feature).

Behaviour:
- Reset, synchronous active-high: state=IDLE; out_data=0, out_ch=0, out_valid=0, busy=0, done=0, out_par=0; the latched mask is cleared. Reset asserted mid-scan aborts the scan with no done pulse.
- slot_free = !out_valid || out_ready. The output register loads only when slot_free; otherwise it holds all values stable.
- Capture latency: 1 cycle. Data loaded at edge t is visible at t+1.
- IDLE, mode=0:
  - If in_valid && slot_free: load in_data[sel], set out_ch=sel, out_valid=1.
  - If in_valid && !slot_free: the request is dropped. Upstream must hold in_valid until it observes the slot free.
  - sel >= N: load 0, out_ch=sel, out_valid=1.
- IDLE, mode=1, start=1:
  - Latch ch_mask into `pend`.
  - If pend==0: stay IDLE and pulse done next cycle; no output.
  - Otherwise go to SCAN with busy=1.
  - start with mode=0 is ignored.
- SCAN:
  - cur = lowest set bit of pend (priority encoder, combinational).
  - When slot_free: load in_data[cur], set out_ch=cur, out_valid=1, clear pend[cur].
  - Masked channels are skipped with zero idle cycles.
  - When the final pending bit is cleared: next state IDLE, busy=0, done=1 for exactly one cycle (same edge as the last load).
  - start, mode, sel, in_valid and ch_mask are all ignored in SCAN.
- out_valid drops only when out_ready=1 and no new load occurs in that cycle. Simultaneous accept and load keeps out_valid=1 (back-to-back throughput of 1 word/cycle).
- in_data is sampled live at capture time; it is not latched at start.

Optional Feature:
- Macro: MUX_SEQ_PARITY_EN.
- Defined: out_par is registered alongside out_data and equals ^data_being_loaded; it holds with out_data.
- Undefined: out_par is tied to 0 and no parity logic is generated.

Decomposition:
- Package mux_seq_pkg:
  - State enum {IDLE, SCAN}.
  - Mode constants MODE_DIRECT=0, MODE_SCAN=1.
  - Lowest-set-bit function used by the priority encoder.
- Sub-module mux_tree_n: parametrised N:1, W-bit combinational mux built recursively from 2:1 stages; instantiated once, driven by the direct-mode or scan index.
- FSM, pend register and output register live in the top module.

Test Plan:
1. Reset behaviour: drive rst=1 mid-scan (mask 16'hFFFF, after 3 words) -> next cycle all outputs 0, busy=0, no done pulse; a new start then begins again at channel 0.
2. Direct mode, N=16, W=8: in_data channel k = 8'h10+k, sel=5, in_valid=1, out_ready=1 -> one cycle later out_data=8'h15, out_ch=5, out_valid=1. Also sel=15 -> out_data=8'h1F.
3. Scan, mask 16'h8421, out_ready=1 -> words 8'h10, 8'h15, 8'h1A, 8'h1F on consecutive cycles; done with the last load; busy high for 4 cycles.
4. Scan backpressure, mask 16'h0003, out_ready=0 for 3 cycles after the first word -> out_data=8'h10 held stable; 8'h11 appears the cycle after out_ready rises; no word lost or duplicated.
5. Scan with mask 16'h0000 -> busy stays 0, done pulses once, out_valid stays 0. start asserted during SCAN -> ignored, sequence unchanged.
6. MUX_SEQ_PARITY_EN defined, direct sel=3 with data 8'h13 -> out_par=1. Undefined -> out_par=0 always.
